// File: rtl/burst_pkg.sv
// Shared definitions for the 16-bit burst request interface.
// Used by sdram_burst_responder and by the initiator cache.
package burst_pkg;

    // Responder FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRCAP    = 3'd3,
        ST_WRCOMMIT = 3'd4
    } state_e;

    localparam int unsigned LINE_WORDS      = 4;
    localparam int unsigned BURST_HALFWORDS = 8;
    localparam int unsigned MIN_LATENCY     = 2;

    localparam int unsigned HALF_W     = 16;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned CNT_W      = 4;   // delay counter width
    localparam int unsigned HW_IDX_W   = 3;   // halfword index within a burst
    localparam int unsigned WORD_IDX_W = 2;   // word index within a line

endpackage

// File: rtl/sdram_burst_responder_if.sv
// Burst request bus between the cache (master) and the memory responder (slave).
//   sdram_req/sdram_rw/sdram_addr : request, direction (1 = line read), byte address
//   data_to_sdram                 : write halfwords, high half first
//   data_from_sdram               : read halfwords
//   sdram_fill                    : per-halfword data strobe
//   busy                          : responder is working on a burst
interface sdram_burst_responder_if;
    import burst_pkg::*;

    logic                  sdram_req;
    logic                  sdram_rw;
    logic [BUS_ADDR_W-1:0] sdram_addr;
    logic [HALF_W-1:0]     data_to_sdram;
    logic [HALF_W-1:0]     data_from_sdram;
    logic                  sdram_fill;
    logic                  busy;

    modport master (
        output sdram_req, sdram_rw, sdram_addr, data_to_sdram,
        input  data_from_sdram, sdram_fill, busy
    );

    modport slave (
        input  sdram_req, sdram_rw, sdram_addr, data_to_sdram,
        output data_from_sdram, sdram_fill, busy
    );

endinterface

// File: rtl/sdram_burst_responder.sv
// Memory-side responder for the burst request bus. A line read returns the four
// words of a 16-byte line as eight halfwords, critical word first, wrapping in
// the line; a word write captures two halfwords and commits one memory write.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   bus           : burst request bus (slave side)
//   mem_addr      : word address to the synchronous memory
//   mem_rd, mem_q : read enable, read data returned the following cycle
//   mem_we, mem_d : one-cycle write enable and write data
module sdram_burst_responder
    import burst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LATENCY    = 3     // legal range 2..15
) (
    input  logic                  clk,
    input  logic                  reset,
    sdram_burst_responder_if.slave bus,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_rd,
    input  logic [WORD_W-1:0]     mem_q,
    output logic                  mem_we,
    output logic [WORD_W-1:0]     mem_d
);

    localparam int unsigned LINE_W = ADDR_WIDTH - 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [HW_IDX_W-1:0] HW_LAST = HW_IDX_W'(BURST_HALFWORDS - 1);

    state_e state, state_nxt;

    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [HW_IDX_W-1:0]   hw, hw_nxt;
    logic [WORD_IDX_W-1:0] start_word;
    logic [LINE_W-1:0]     line;
    logic                  rw;
    logic [HALF_W-1:0]     lo_hold, lo_hold_nxt;

    logic [HALF_W-1:0]     data_nxt;
    logic                  fill_nxt;
    logic                  busy_nxt;
    logic [ADDR_WIDTH-3:0] mem_addr_nxt;
    logic                  mem_rd_nxt;
    logic                  mem_we_nxt;
    logic [WORD_W-1:0]     mem_d_nxt;

    // Only ADDR_WIDTH-1:2 is decoded; the rest of the byte address aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.sdram_addr;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (bus.sdram_req) state_nxt = ST_DELAY;
            ST_DELAY:    if (cnt == '0) state_nxt = rw ? ST_READ : ST_WRCAP;
            ST_READ:     if (hw == HW_LAST) state_nxt = ST_IDLE;
            ST_WRCAP:    if (hw[0]) state_nxt = ST_WRCOMMIT;
            ST_WRCOMMIT: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values (registered below)
    always_comb begin
        cnt_nxt      = cnt;
        hw_nxt       = hw;
        lo_hold_nxt  = lo_hold;
        data_nxt     = bus.data_from_sdram;
        fill_nxt     = 1'b0;
        busy_nxt     = (state_nxt != ST_IDLE);
        mem_addr_nxt = mem_addr;
        mem_rd_nxt   = 1'b0;
        mem_we_nxt   = 1'b0;
        mem_d_nxt    = mem_d;

        case (state)
            ST_IDLE: begin
                cnt_nxt = CNT_LOAD;
                // At the minimum latency the first read must go out with the sample.
                if (bus.sdram_req && bus.sdram_rw && (CNT_LOAD == CNT_W'(1))) begin
                    mem_rd_nxt   = 1'b1;
                    mem_addr_nxt = bus.sdram_addr[ADDR_WIDTH-1:2];
                end
            end

            ST_DELAY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    // Read of the critical word lands two cycles before the first fill.
                    if (rw && (cnt == CNT_W'(2))) begin
                        mem_rd_nxt   = 1'b1;
                        mem_addr_nxt = {line, start_word};
                    end
                end else begin
                    hw_nxt   = '0;
                    fill_nxt = 1'b1;
                    if (rw) begin
                        data_nxt     = mem_q[WORD_W-1:HALF_W];
                        lo_hold_nxt  = mem_q[HALF_W-1:0];
                        mem_rd_nxt   = 1'b1;
                        mem_addr_nxt = {line, start_word + WORD_IDX_W'(1)};
                    end
                end
            end

            ST_READ: begin
                if (hw != HW_LAST) begin
                    hw_nxt   = hw + HW_IDX_W'(1);
                    fill_nxt = 1'b1;
                    if (!hw[0]) begin
                        data_nxt = lo_hold;
                    end else begin
                        data_nxt    = mem_q[WORD_W-1:HALF_W];
                        lo_hold_nxt = mem_q[HALF_W-1:0];
                        // Prefetch the word after the one being presented; the last word needs none.
                        if (hw != HW_IDX_W'(5)) begin
                            mem_rd_nxt   = 1'b1;
                            mem_addr_nxt = {line, start_word + hw[2:1] + WORD_IDX_W'(2)};
                        end
                    end
                end
            end

            ST_WRCAP: begin
                if (!hw[0]) begin
                    mem_d_nxt[WORD_W-1:HALF_W] = bus.data_to_sdram;
                    hw_nxt   = HW_IDX_W'(1);
                    fill_nxt = 1'b1;
                end else begin
                    mem_d_nxt[HALF_W-1:0] = bus.data_to_sdram;
                    mem_we_nxt   = 1'b1;
                    mem_addr_nxt = {line, start_word};
                end
            end

            default: ;
        endcase
    end

    // Request capture, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt                 <= '0;
            hw                  <= '0;
            start_word          <= '0;
            line                <= '0;
            rw                  <= 1'b0;
            lo_hold             <= '0;
            bus.data_from_sdram <= '0;
            bus.sdram_fill      <= 1'b0;
            bus.busy            <= 1'b0;
            mem_addr            <= '0;
            mem_rd              <= 1'b0;
            mem_we              <= 1'b0;
            mem_d               <= '0;
        end else begin
            if ((state == ST_IDLE) && bus.sdram_req) begin
                line       <= bus.sdram_addr[ADDR_WIDTH-1:4];
                start_word <= bus.sdram_addr[3:2];
                rw         <= bus.sdram_rw;
            end
            cnt                 <= cnt_nxt;
            hw                  <= hw_nxt;
            lo_hold             <= lo_hold_nxt;
            bus.data_from_sdram <= data_nxt;
            bus.sdram_fill      <= fill_nxt;
            bus.busy            <= busy_nxt;
            mem_addr            <= mem_addr_nxt;
            mem_rd              <= mem_rd_nxt;
            mem_we              <= mem_we_nxt;
            mem_d               <= mem_d_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed bench for sdram_burst_responder: one instance at LATENCY 3 and one at
// LATENCY 2, each with its own synchronous memory model.
// Cycle n below is the period following clock edge n; a request is sampled at edge 0.
module tb_sdram_burst_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    sdram_burst_responder_if bus ();
    sdram_burst_responder_if bus2 ();

    logic [13:0] mem_addr, mem2_addr;
    logic        mem_rd, mem2_rd, mem_we, mem2_we;
    logic [31:0] mem_q = '0;
    logic [31:0] mem2_q = '0;
    logic [31:0] mem_d, mem2_d;
    logic [31:0] mem [0:16383];
    int          we_count = 0;

    sdram_burst_responder #(.ADDR_WIDTH(16), .LATENCY(3)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
        .mem_we(mem_we), .mem_d(mem_d)
    );

    sdram_burst_responder #(.ADDR_WIDTH(16), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .mem_addr(mem2_addr), .mem_rd(mem2_rd), .mem_q(mem2_q),
        .mem_we(mem2_we), .mem_d(mem2_d)
    );

    // Synchronous memory: read data one cycle after mem_rd
    always @(posedge clk) begin
        if (mem_rd) mem_q <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_d;
            we_count <= we_count + 1;
        end
        if (mem2_rd) mem2_q <= {16'hA000 + 16'(mem2_addr), 16'hB000 + 16'(mem2_addr)};
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From cycle 0 of a LATENCY-3 read on bus: expects two quiet cycles then eight fills.
    task automatic read_fills(input string tag, input logic [127:0] e, input int drop_idx);
        logic [15:0] ev;
        for (int c = 1; c <= 2; c++) begin
            tick();
            check($sformatf("%s_prefill%0d", tag, c), 32'(bus.sdram_fill), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == drop_idx) bus.sdram_req = 1'b0;
            ev = e[127 - 16*i -: 16];
            check($sformatf("%s_fill%0d", tag, i), 32'(bus.sdram_fill), 32'd1);
            check($sformatf("%s_data%0d", tag, i), 32'(bus.data_from_sdram), 32'(ev));
        end
    endtask

    initial begin
        for (int w = 0; w < 16384; w++) mem[w] = {16'hA000 + 16'(w), 16'hB000 + 16'(w)};
        bus.sdram_req = 1'b0;  bus.sdram_rw = 1'b0;  bus.sdram_addr = '0;  bus.data_to_sdram = '0;
        bus2.sdram_req = 1'b0; bus2.sdram_rw = 1'b0; bus2.sdram_addr = '0; bus2.data_to_sdram = '0;
        reset = 1'b0;
        tick(2);
        check("rst_fill", 32'(bus.sdram_fill), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mem_rd_we", 32'({mem_rd, mem_we}), 32'd0);
        reset = 1'b1;
        tick(2);

        // Read 0x18: critical word 6, wraps to 4 and 5
        bus.sdram_req = 1'b1; bus.sdram_rw = 1'b1; bus.sdram_addr = 32'h0000_0018;
        tick();
        bus.sdram_req = 1'b0;
        check("r18_busy_c0", 32'(bus.busy), 32'd1);
        read_fills("r18", {16'hA006, 16'hB006, 16'hA007, 16'hB007,
                           16'hA004, 16'hB004, 16'hA005, 16'hB005}, 99);
        tick();
        check("r18_busy_c11", 32'(bus.busy), 32'd0);
        check("r18_fill_c11", 32'(bus.sdram_fill), 32'd0);
        tick(2);

        // Read 0x20, request dropped during the burst; no second burst
        bus.sdram_req = 1'b1; bus.sdram_rw = 1'b1; bus.sdram_addr = 32'h0000_0020;
        tick();
        read_fills("r20", {16'hA008, 16'hB008, 16'hA009, 16'hB009,
                           16'hA00A, 16'hB00A, 16'hA00B, 16'hB00B}, 1);
        tick();
        check("r20_busy_c11", 32'(bus.busy), 32'd0);
        tick(3);
        check("r20_no_rerun_busy", 32'(bus.busy), 32'd0);
        check("r20_no_rerun_fill", 32'(bus.sdram_fill), 32'd0);

        // Write 0x44 = 0x12345678 to word 0x11
        bus.sdram_req = 1'b1; bus.sdram_rw = 1'b0; bus.sdram_addr = 32'h0000_0044;
        tick();
        bus.sdram_req = 1'b0;
        tick(2);
        check("w44_fill_c2", 32'(bus.sdram_fill), 32'd0);
        tick();
        check("w44_fill_c3", 32'(bus.sdram_fill), 32'd1);
        bus.data_to_sdram = 16'h1234;
        tick();
        check("w44_fill_c4", 32'(bus.sdram_fill), 32'd1);
        check("w44_we_c4", 32'(mem_we), 32'd0);
        bus.data_to_sdram = 16'h5678;
        tick();
        bus.data_to_sdram = 16'h0000;
        check("w44_we_c5", 32'(mem_we), 32'd1);
        check("w44_addr_c5", 32'(mem_addr), 32'h0000_0011);
        check("w44_d_c5", mem_d, 32'h1234_5678);
        check("w44_fill_c5", 32'(bus.sdram_fill), 32'd0);
        tick();
        check("w44_we_c6", 32'(mem_we), 32'd0);
        check("w44_busy_c6", 32'(bus.busy), 32'd0);
        check("w44_mem", mem[14'h011], 32'h1234_5678);
        tick();

        // Read back 0x44
        bus.sdram_req = 1'b1; bus.sdram_rw = 1'b1; bus.sdram_addr = 32'h0000_0044;
        tick();
        bus.sdram_req = 1'b0;
        read_fills("r44", {16'h1234, 16'h5678, 16'hA012, 16'hB012,
                           16'hA013, 16'hB013, 16'hA010, 16'hB010}, 99);
        tick(2);

        // Request held high: second read sampled at IDLE
        bus.sdram_req = 1'b1; bus.sdram_rw = 1'b1; bus.sdram_addr = 32'h0000_0000;
        tick();
        read_fills("b2b_a", {16'hA000, 16'hB000, 16'hA001, 16'hB001,
                             16'hA002, 16'hB002, 16'hA003, 16'hB003}, 99);
        tick();
        check("b2b_busy_c11", 32'(bus.busy), 32'd0);
        check("b2b_fill_c11", 32'(bus.sdram_fill), 32'd0);
        bus.sdram_addr = 32'h0000_0010;
        tick();
        check("b2b_busy_c12", 32'(bus.busy), 32'd1);
        check("b2b_fill_c12", 32'(bus.sdram_fill), 32'd0);
        read_fills("b2b_b", {16'hA004, 16'hB004, 16'hA005, 16'hB005,
                             16'hA006, 16'hB006, 16'hA007, 16'hB007}, 0);
        tick();
        check("b2b_b_busy_end", 32'(bus.busy), 32'd0);
        tick(2);

        // Reset during the 4th fill of a read
        bus.sdram_req = 1'b1; bus.sdram_rw = 1'b1; bus.sdram_addr = 32'h0000_0000;
        tick();
        bus.sdram_req = 1'b0;
        tick(6);
        check("rst4_fill_before", 32'(bus.sdram_fill), 32'd1);
        check("rst4_data_before", 32'(bus.data_from_sdram), 32'h0000_B001);
        reset = 1'b0;
        #1;
        check("rst4_fill", 32'(bus.sdram_fill), 32'd0);
        check("rst4_busy", 32'(bus.busy), 32'd0);
        check("rst4_data", 32'(bus.data_from_sdram), 32'd0);
        check("rst4_mem_rd", 32'(mem_rd), 32'd0);
        check("rst4_mem_we", 32'(mem_we), 32'd0);
        check("rst4_mem_d", mem_d, 32'd0);
        check("rst4_mem_addr", 32'(mem_addr), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(2);
        check("rst4_no_write", 32'(we_count), 32'd1);
        bus.sdram_req = 1'b1; bus.sdram_rw = 1'b1; bus.sdram_addr = 32'h0000_0000;
        tick();
        bus.sdram_req = 1'b0;
        read_fills("rst4_after", {16'hA000, 16'hB000, 16'hA001, 16'hB001,
                                  16'hA002, 16'hB002, 16'hA003, 16'hB003}, 99);
        tick();
        check("rst4_after_busy", 32'(bus.busy), 32'd0);

        // LATENCY 2 instance: read 0x0C, first fill at cycle 2
        bus2.sdram_req = 1'b1; bus2.sdram_rw = 1'b1; bus2.sdram_addr = 32'h0000_000C;
        tick();
        bus2.sdram_req = 1'b0;
        check("l2_busy_c0", 32'(bus2.busy), 32'd1);
        tick();
        check("l2_fill_c1", 32'(bus2.sdram_fill), 32'd0);
        begin
            logic [127:0] e2;
            logic [15:0]  ev;
            e2 = {16'hA003, 16'hB003, 16'hA000, 16'hB000,
                  16'hA001, 16'hB001, 16'hA002, 16'hB002};
            for (int i = 0; i < 8; i++) begin
                tick();
                ev = e2[127 - 16*i -: 16];
                check($sformatf("l2_fill%0d", i), 32'(bus2.sdram_fill), 32'd1);
                check($sformatf("l2_data%0d", i), 32'(bus2.data_from_sdram), 32'(ev));
            end
        end
        tick();
        check("l2_busy_c10", 32'(bus2.busy), 32'd0);
        check("l2_fill_c10", 32'(bus2.sdram_fill), 32'd0);
        check("l2_no_write", 32'(mem2_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_burst_responder.md
# sdram_burst_responder

Memory-side responder for the 16-bit burst request interface used by the CPU burst cache. It accepts a cache-line request, reads four 32-bit words from a synchronous on-chip memory, and returns them as eight consecutive 16-bit halfwords with `sdram_fill` asserted. Data comes back critical-word-first, wrapping within the 16-byte line. Single-word writes are also accepted. The block lets the cache run against block RAM in simulation and in SDRAM-less builds.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: byte-address bits decoded. Higher `sdram_addr` bits are ignored and alias.
- `LATENCY`, 3: cycles from request sample to first `sdram_fill`. Legal range 2..15.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `sdram_req`  in  1  request from the initiator. Sampled only in IDLE.
- `sdram_rw`  in  1  1 = line read, 0 = word write. Sampled with `sdram_req`.
- `sdram_addr`  in  32  byte address. Bits [3:2] select the critical word.
- `data_to_sdram`  in  16  write data. High half first, then low half.
- `data_from_sdram`  out  16  read halfword, registered.
- `sdram_fill`  out  1  data strobe for read halfwords and write halfwords.
- `busy`  out  1  high from request sample until return to IDLE.
- `mem_addr`  out  ADDR_WIDTH-2  word address to memory.
- `mem_rd`  out  1  read enable. Memory returns `mem_q` on the next cycle.
- `mem_q`  in  32  memory read data.
- `mem_we`  out  1  write enable, one-cycle pulse.
- `mem_d`  out  32  write data.

## Operation
- States: IDLE, DELAY, READ, WRCAP, WRCOMMIT.
- IDLE:
  - When `sdram_req` = 1, latch the line address `sdram_addr[ADDR_WIDTH-1:4]`, the start word `a = sdram_addr[3:2]` and `sdram_rw`.
  - Set `busy`, load the delay counter with `LATENCY-1`, go to DELAY.
- DELAY:
  - Count down to 0.
  - For reads, issue `mem_rd` for word `a` exactly 2 cycles before the first fill, so read data is ready one cycle ahead.
  - On 0, go to READ (rw=1) or WRCAP (rw=0).
- READ:
  - Halfword index `j` = 0..7. Word index = `(a + j/2) mod 4`.
  - Even `j` outputs `mem_q[31:16]`; odd `j` outputs the low half of the same word, held in a register.
  - The next word's `mem_rd` is issued during the even-`j` cycle.
  - `sdram_fill` = 1 for all 8 cycles, with no gaps. The initiator latches the second half of each word unconditionally on the cycle after the first, so gaps are forbidden.
  - After `j` = 7, go to IDLE.
- WRCAP:
  - 2 cycles with `sdram_fill` = 1.
  - Capture `data_to_sdram` into `mem_d[31:16]`, then into `mem_d[15:0]`.
- WRCOMMIT:
  - `mem_we` = 1 for one cycle, `mem_addr` = latched line address concatenated with `a`.
  - Go to IDLE.
- `sdram_req` may drop at any point after it is sampled; the burst always completes.
- `sdram_req` held high is not re-sampled until IDLE.
- Reset (async, any state) values:
  - state IDLE.
  - `sdram_fill`, `busy`, `mem_rd`, `mem_we` = 0.
  - `data_from_sdram`, `mem_d`, `mem_addr` = 0.
  - An in-flight burst is abandoned with no memory write.

## Timing
- Request sampled at cycle 0. Read fills on cycles `LATENCY` .. `LATENCY+7`. IDLE at cycle `LATENCY+8`, and a new request is accepted that cycle.
- `sdram_fill` is low for at least `LATENCY` cycles between bursts. This satisfies an initiator that waits for fill low before returning to idle.
- Write fills on cycles `LATENCY` and `LATENCY+1`. `mem_we` on cycle `LATENCY+2`. IDLE at `LATENCY+3`.
- `busy` rises the cycle after the sample and falls on entry to IDLE.
- Word-index arithmetic is 2-bit and wraps modulo 4. Line address bits are never incremented.

## Structure
- Shared package `burst_pkg` holds:
  - the state enum;
  - `LINE_WORDS` = 4;
  - `BURST_HALFWORDS` = 8;
  - `MIN_LATENCY` = 2.
- The initiator cache reuses `LINE_WORDS` and `BURST_HALFWORDS`.
- No sub-module is natural; the block is a single FSM with a 3-bit halfword counter and a 4-bit delay counter.

## Test plan
Memory model: word `w` = {16'hA000+w, 16'hB000+w}. `LATENCY` = 3 unless stated.
- Read `sdram_addr` = 0x0000_0018 -> fills on cycles 3..10 carry A006, B006, A007, B007, A004, B004, A005, B005. `busy` low at cycle 11.
- Read addr 0x0000_0020, with `sdram_req` dropped one cycle after the first fill -> A008, B008 … A00B, B00B with 8 continuous fills. No second burst starts.
- Write addr 0x0000_0044 with `data_to_sdram` = 0x1234 then 0x5678 on fill cycles 3 and 4 -> `mem_we` at cycle 5 with `mem_addr` = 0x011 and `mem_d` = 0x12345678. A subsequent read of 0x44 returns 0x1234 first.
- `sdram_req` held high continuously for two reads -> the second is sampled exactly at IDLE. `sdram_fill` is low for ≥3 cycles between the bursts.
- Reset asserted at the 4th fill of a read -> all outputs 0 asynchronously. After release, a new request at 0x0 returns A000 first with correct timing.
- `LATENCY` = 2, read addr 0x0000_000C -> first fill at cycle 2 = A003, then B003, A000 …, ending B002. No gap in `sdram_fill`.
